// File: rtl/cpu_loader.sv
// Host-side loader for the 8-bit CPU: streams a program into IRAM and data into
// DRAM, runs the CPU with a watchdog, then returns a fixed DRAM window to the host.
module cpu_loader #(
  parameter int N_OUT   = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        mem_sel,
  output logic [7:0]  iram_addr,
  output logic [15:0] iram_din,
  output logic        iram_write,
  output logic [7:0]  dram_addr,
  output logic [7:0]  dram_din,
  output logic        dram_write,
  input  logic [7:0]  dram_dout,
  output logic        cpu_start,
  input  logic        cpu_idle,
  output logic        err,
  output logic [3:0]  state_dbg
);

  // Handshake: a byte moves on either stream only at a rising edge where
  // valid and ready are both high; m_data is held while m_valid waits on m_ready.

  typedef enum logic [3:0] {
    S_HDR_I, S_I_LO, S_I_HI, S_HDR_D, S_D,
    S_START, S_RUN, S_RD_ADDR, S_RD_WAIT, S_SEND
  } state_t;

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    LAST_RD  = 8'(N_OUT - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [7:0]    addr_cnt;
  logic [7:0]    last_idx;
  logic [7:0]    lo_byte;
  logic [7:0]    rd_cnt;
  logic [TW-1:0] tmr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_HDR_I;
      addr_cnt <= '0;
      last_idx <= '0;
      lo_byte  <= '0;
      rd_cnt   <= '0;
      tmr      <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_HDR_I: if (s_valid) begin
          addr_cnt <= '0;
          last_idx <= s_data - 8'd1;
          state    <= (s_data == 8'd0) ? S_HDR_D : S_I_LO;
        end
        S_I_LO: if (s_valid) begin
          lo_byte <= s_data;
          state   <= S_I_HI;
        end
        S_I_HI: if (s_valid) begin
          addr_cnt <= addr_cnt + 8'd1;
          state    <= (addr_cnt == last_idx) ? S_HDR_D : S_I_LO;
        end
        S_HDR_D: if (s_valid) begin
          addr_cnt <= '0;
          last_idx <= s_data - 8'd1;
          state    <= (s_data == 8'd0) ? S_START : S_D;
        end
        S_D: if (s_valid) begin
          addr_cnt <= addr_cnt + 8'd1;
          if (addr_cnt == last_idx) state <= S_START;
        end
        S_START: begin
          tmr   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          tmr <= tmr + 1'b1;
          // cpu_idle is still stale on the first run cycle, so tmr==0 is skipped
          if (tmr != '0 && cpu_idle) begin
            rd_cnt <= '0;
            state  <= S_RD_ADDR;
          end else if (tmr == TMR_LAST) begin
            err    <= 1'b1;
            rd_cnt <= '0;
            state  <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          m_data  <= dram_dout;
          m_valid <= 1'b1;
          state   <= S_SEND;
        end
        S_SEND: if (m_ready) begin
          m_valid <= 1'b0;
          rd_cnt  <= rd_cnt + 8'd1;
          state   <= (rd_cnt == LAST_RD) ? S_HDR_I : S_RD_ADDR;
        end
        default: state <= S_HDR_I;
      endcase
    end
  end

  // RAM strobes and buses follow the accepted byte in the same cycle.
  always_comb begin
    s_ready    = (state == S_HDR_I) || (state == S_I_LO) || (state == S_I_HI) ||
                 (state == S_HDR_D) || (state == S_D);
    mem_sel    = !((state == S_START) || (state == S_RUN));
    cpu_start  = (state == S_START);
    iram_write = (state == S_I_HI) && s_valid;
    iram_addr  = iram_write ? addr_cnt : 8'd0;
    iram_din   = iram_write ? {s_data, lo_byte} : 16'd0;
    dram_write = (state == S_D) && s_valid;
    dram_din   = dram_write ? s_data : 8'd0;
    if (dram_write)              dram_addr = addr_cnt;
    else if (state == S_RD_ADDR) dram_addr = rd_cnt;
    else                         dram_addr = 8'd0;
    state_dbg  = state;
  end

endmodule

// File: tb/tb_cpu_loader.sv
// Bench for cpu_loader: random host streams, RAM/CPU models and a scoreboard
// comparing the returned DRAM window and RAM images against a reference image.
module tb_cpu_loader;
  localparam int N_OUT   = 3;
  localparam int TIMEOUT = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        mem_sel;
  logic [7:0]  iram_addr;
  logic [15:0] iram_din;
  logic        iram_write;
  logic [7:0]  dram_addr;
  logic [7:0]  dram_din;
  logic        dram_write;
  logic [7:0]  dram_dout = 8'd0;
  logic        cpu_start;
  logic        cpu_idle = 1'b1;
  logic        err;
  logic [3:0]  state_dbg;

  always #5 clk = ~clk;

  cpu_loader #(.N_OUT(N_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .mem_sel(mem_sel),
    .iram_addr(iram_addr), .iram_din(iram_din), .iram_write(iram_write),
    .dram_addr(dram_addr), .dram_din(dram_din), .dram_write(dram_write),
    .dram_dout(dram_dout), .cpu_start(cpu_start), .cpu_idle(cpu_idle),
    .err(err), .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- RAM and CPU models ----------------
  logic [15:0] iram [256];
  logic [7:0]  dram [256];
  logic [15:0] ref_iram [256];
  logic [7:0]  ref_dram [256];
  bit mem_init = 1'b0;
  logic cpu_we = 1'b0;
  logic cpu_pend = 1'b0;
  int   busy = 0;
  int   cpu_run_len = 5;
  bit   cpu_hang = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) begin
        iram[i] <= 16'hC000 | 16'(i);
        dram[i] <= 8'(i) ^ 8'h5A;
      end
      mem_init <= 1'b1;
    end else begin
      if (mem_sel && iram_write) iram[iram_addr] <= iram_din;
      if (mem_sel && dram_write) dram[dram_addr] <= dram_din;
      if (!mem_sel && cpu_we)    dram[0] <= dram[0] + 8'd1;
      dram_dout <= dram[mem_sel ? dram_addr : 8'd0];
    end
  end

  // CPU leaves idle one cycle after the start pulse, runs, then bumps DRAM[0].
  always @(posedge clk) begin
    cpu_we <= 1'b0;
    if (cpu_start) cpu_pend <= 1'b1;
    else if (cpu_pend) begin
      cpu_pend <= 1'b0;
      cpu_idle <= 1'b0;
      busy     <= cpu_run_len;
    end else if (!cpu_idle && !cpu_hang) begin
      if (busy <= 1) begin
        cpu_idle <= 1'b1;
        cpu_we   <= 1'b1;
      end else busy <= busy - 1;
    end
  end

  // ---------------- host sink ----------------
  bit stall_mode = 1'b0;
  int hold = 0;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_mode) begin
        if (m_valid && hold >= 4) begin
          m_ready = 1'b1;
          hold = 0;
        end else begin
          m_ready = 1'b0;
          if (m_valid) hold++;
        end
      end else m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  bit exp_err = 1'b0;
  int cyc = 0, last_acc = 0, start_cyc = 0;
  int n_iw = 0, n_dw = 0, n_start = 0;
  bit prev_mv = 1'b0, prev_mr = 1'b0, prev_err = 1'b0;
  logic [7:0] prev_md = 8'd0;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_mv  = 1'b0;
      prev_mr  = 1'b0;
      prev_err = 1'b0;
    end else begin
      cyc++;
      if (s_valid && s_ready) last_acc = cyc;
      if (iram_write) n_iw++;
      if (dram_write) n_dw++;
      if (cpu_start) begin
        n_start++;
        start_cyc = cyc;
        check("start_after_last_byte", cyc, last_acc + 1);
      end
      if (prev_mv && !prev_mr) begin
        check("m_valid_hold", {31'd0, m_valid}, 32'd1);
        check("m_data_hold", {24'd0, m_data}, {24'd0, prev_md});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %0h expected none", m_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("m_data", {24'd0, m_data}, {24'd0, exp_b});
          check("err_at_readback", {31'd0, err}, {31'd0, exp_err});
        end
      end
      // err rises once TIMEOUT full S_RUN cycles follow the start cycle
      if (err && !prev_err) check("err_rise_cycle", cyc - start_cyc, TIMEOUT + 1);
      prev_mv  = m_valid;
      prev_mr  = m_ready;
      prev_md  = m_data;
      prev_err = err;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 2000) begin
        check("s_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  logic [15:0] wq[$];
  logic [7:0]  dq[$];

  // Reference: RAM image = previous image with the loaded words/bytes overlaid,
  // plus one increment of DRAM[0] per completed CPU run.
  task automatic run_stream(input bit gaps, input bit stall, input int run_len, input bit hang);
    logic [7:0] bytes[$];
    int iw0, dw0, st0, n, bad;
    bytes.push_back(8'(wq.size()));
    foreach (wq[i]) begin
      ref_iram[i] = wq[i];
      bytes.push_back(wq[i][7:0]);
      bytes.push_back(wq[i][15:8]);
    end
    bytes.push_back(8'(dq.size()));
    foreach (dq[i]) begin
      ref_dram[i] = dq[i];
      bytes.push_back(dq[i]);
    end
    if (!hang) ref_dram[0] = ref_dram[0] + 8'd1;
    for (int i = 0; i < N_OUT; i++) exp_q.push_back(ref_dram[i]);
    cpu_run_len = run_len;
    cpu_hang    = hang;
    stall_mode  = stall;
    iw0 = n_iw; dw0 = n_dw; st0 = n_start;
    foreach (bytes[i]) send_byte(bytes[i], gaps);
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      check("readback_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("s_ready_after_readback", {31'd0, s_ready}, 32'd1);
    check("iram_write_count", n_iw - iw0, wq.size());
    check("dram_write_count", n_dw - dw0, dq.size());
    check("start_pulse_count", n_start - st0, 1);
    bad = -1;
    for (int i = 0; i < 256; i++) if (bad < 0 && iram[i] !== ref_iram[i]) bad = i;
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL iram_image: addr %0d got %0h expected %0h", bad, iram[bad], ref_iram[bad]);
    end
    bad = -1;
    for (int i = 0; i < 256; i++) if (bad < 0 && dram[i] !== ref_dram[i]) bad = i;
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL dram_image: addr %0d got %0h expected %0h", bad, dram[bad], ref_dram[bad]);
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_payload(input int ni, input int nd);
    wq.delete();
    dq.delete();
    for (int i = 0; i < ni; i++) wq.push_back(16'($urandom));
    for (int i = 0; i < nd; i++) dq.push_back(8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},    {31'd0, s_ready},    32'd1);
    check({tag, "_m_valid"},    {31'd0, m_valid},    32'd0);
    check({tag, "_m_data"},     {24'd0, m_data},     32'd0);
    check({tag, "_mem_sel"},    {31'd0, mem_sel},    32'd1);
    check({tag, "_iram_write"}, {31'd0, iram_write}, 32'd0);
    check({tag, "_iram_addr"},  {24'd0, iram_addr},  32'd0);
    check({tag, "_iram_din"},   {16'd0, iram_din},   32'd0);
    check({tag, "_dram_write"}, {31'd0, dram_write}, 32'd0);
    check({tag, "_dram_addr"},  {24'd0, dram_addr},  32'd0);
    check({tag, "_dram_din"},   {24'd0, dram_din},   32'd0);
    check({tag, "_cpu_start"},  {31'd0, cpu_start},  32'd0);
    check({tag, "_err"},        {31'd0, err},        32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_iram[i] = 16'hC000 | 16'(i);
      ref_dram[i] = 8'(i) ^ 8'h5A;
    end
    s_data = 8'hA7;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // two fixed instructions, no data
    wq = '{16'h0215, 16'h0000};
    dq.delete();
    run_stream(1'b0, 1'b0, 5, 1'b0);

    // three data bytes, CPU busy for 5 cycles
    wq.delete();
    dq = '{8'h11, 8'h22, 8'h33};
    run_stream(1'b0, 1'b0, 5, 1'b0);

    // random payloads with input gaps and a slow host
    for (int k = 0; k < 4; k++) begin
      rand_payload($urandom_range(1, 6), $urandom_range(1, 6));
      run_stream(1'b1, 1'b1, $urandom_range(1, 7), 1'b0);
    end

    // empty stream: start follows the second header directly
    rand_payload(0, 0);
    run_stream(1'b0, 1'b0, 3, 1'b0);

    // full-size sections: last writes land on address 254
    rand_payload(255, 255);
    run_stream(1'b0, 1'b0, 2, 1'b0);

    // CPU never returns idle: watchdog fires, readback still happens
    rand_payload(2, 2);
    exp_err = 1'b1;
    run_stream(1'b0, 1'b0, 5, 1'b1);
    rand_payload(1, 3);
    run_stream(1'b1, 1'b0, 4, 1'b0);

    // reset while the high byte of an instruction is on the bus
    send_byte(8'd3, 1'b0);
    send_byte(8'h44, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h99;
    #2;
    exp_err = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    rand_payload(3, 2);
    run_stream(1'b1, 1'b1, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
